waveform_pwm_dac: RTL and testbench

- Output end of the synth waveform path: consumes the 8-bit unsigned samples that TopLevel produces on Waveform and converts them to a single-bit PWM stream for an external RC-filtered audio pin.
- Sample input uses a valid/ready handshake with a one-entry holding buffer.
- The active duty value is swapped only at PWM period boundaries, so a period is never glitched.

---
 rtl/waveform_pwm_dac.sv | 85 ++++++++
 tb/tb_waveform_pwm_dac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/waveform_pwm_dac.sv
// Single-bit PWM DAC for unsigned audio samples with a one-entry holding buffer.
// The duty value only changes at period boundaries, so every period is a clean pulse.
module waveform_pwm_dac #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             sample_valid_i,
    output logic             sample_ready_o,
    output logic             pwm_o,
    output logic             frame_start_o,
    output logic             underrun_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    prescale_q, prescale_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             full_q, full_d;
    logic             pwm_q, pwm_d;
    logic             frame_q, frame_d;
    logic             under_q, under_d;

    logic tick;
    logic boundary;
    logic accept;

    assign tick     = (prescale_q == PW'(PRESCALE - 1));
    assign boundary = tick && (cnt_q == {WIDTH{1'b1}});
    assign accept   = sample_valid_i && !full_q;

    always_comb begin
        prescale_d = tick ? '0 : prescale_q + PW'(1);
        cnt_d      = tick ? cnt_q + WIDTH'(1) : cnt_q;
        active_d   = active_q;
        buf_d      = buf_q;
        full_d     = full_q;
        frame_d    = boundary;
        under_d    = boundary && !full_q;

        // A full buffer can never accept, so the load and the fill never collide.
        if (boundary && full_q) begin
            active_d = buf_q;
            full_d   = 1'b0;
        end
        if (accept) begin
            buf_d  = sample_i;
            full_d = 1'b1;
        end

        pwm_d = tick ? (cnt_d < active_d) : pwm_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale_q <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            buf_q      <= '0;
            full_q     <= 1'b0;
            pwm_q      <= 1'b0;
            frame_q    <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            pwm_q      <= pwm_d;
            frame_q    <= frame_d;
            under_q    <= under_d;
        end
    end

    assign sample_ready_o = !full_q;
    assign pwm_o          = pwm_q;
    assign frame_start_o  = frame_q;
    assign underrun_o     = under_q;

endmodule

// File: tb/tb_waveform_pwm_dac.sv
// Bench for waveform_pwm_dac: instance 0 runs PRESCALE=1, instance 1 runs PRESCALE=3.
// A time-position model predicts every output each cycle; directed periods pin it with literals.
module tb_waveform_pwm_dac;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       vld [2];
    logic       rdy [2];
    logic       pwm [2];
    logic       fs  [2];
    logic       ur  [2];

    int vectors    = 0;
    int miscompares = 0;

    waveform_pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sample_i(din), .sample_valid_i(vld[0]),
        .sample_ready_o(rdy[0]), .pwm_o(pwm[0]), .frame_start_o(fs[0]), .underrun_o(ur[0])
    );

    waveform_pwm_dac #(.WIDTH(8), .PRESCALE(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sample_i(din), .sample_valid_i(vld[1]),
        .sample_ready_o(rdy[1]), .pwm_o(pwm[1]), .frame_start_o(fs[1]), .underrun_o(ur[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: n counts clocks since reset release; a period spans 256*P clocks and is
    // high for the first duty*P of them. Pending/duty follow the buffer rules per period.
    int         n    [2] = '{0, 0};
    bit         pend [2] = '{0, 0};
    logic [7:0] pval [2] = '{8'h00, 8'h00};
    int         act  [2] = '{0, 0};
    bit         eP   [2] = '{0, 0};
    bit         eF   [2] = '{0, 0};
    bit         eU   [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                n[i] = 0; pend[i] = 0; act[i] = 0;
                eP[i] = 0; eF[i] = 0; eU[i] = 0;
            end else begin
                automatic int ps  = (i == 0) ? 1 : 3;
                automatic int len = 256 * ps;
                automatic bit acc = vld[i] && !pend[i];
                n[i]++;
                eF[i] = (n[i] % len == 0);
                eU[i] = 1'b0;
                if (eF[i]) begin
                    if (pend[i]) begin
                        act[i]  = int'(pval[i]);
                        pend[i] = 0;
                    end else begin
                        eU[i] = 1'b1;
                    end
                end
                if (acc) begin
                    pend[i] = 1;
                    pval[i] = din;
                end
                eP[i] = ((n[i] % len) < act[i] * ps);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("pwm%0d", i),   32'(pwm[i]), 32'(eP[i]));
            checkOutput($sformatf("frame%0d", i), 32'(fs[i]),  32'(eF[i]));
            checkOutput($sformatf("under%0d", i), 32'(ur[i]),  32'(eU[i]));
            checkOutput($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!pend[i]));
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input int inst, input logic [7:0] val);
        bit acc = 0;
        int guard = 0;
        din = val;
        vld[inst] = 1'b1;
        while (!acc && guard < 3000) begin
            acc = rdy[inst];
            @(negedge clk);
            guard++;
        end
        vld[inst] = 1'b0;
        if (!acc) checkOutput("accept_timeout", 0, 1);
        else      checkOutput("ready_low_after_accept", 32'(rdy[inst]), 0);
    endtask

    task automatic waitFrame(input int inst, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!fs[inst] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        ok = fs[inst];
        if (!ok) checkOutput("frame_timeout", 0, 1);
    endtask

    task automatic measurePeriod(input int inst, output int hi, output int len, output bit urStart);
        bit ok;
        hi = 0; len = 0; urStart = 0;
        waitFrame(inst, ok);
        if (ok) begin
            urStart = ur[inst];
            do begin
                if (pwm[inst]) hi++;
                len++;
                @(negedge clk);
            end while (!fs[inst] && len < 3000);
        end
    endtask

    int hi, len, hi2, len2;
    bit urs, urs2, ok;

    initial begin
        rst_n = 1'b0;
        din = 8'h00;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm", 32'(pwm[0]), 0);
        checkOutput("reset_ready", 32'(rdy[0]), 1);
        rst_n = 1'b1;

        // Idle: silence with an underrun on every frame.
        measurePeriod(0, hi, len, urs);
        checkOutput("idle_len", len, 256);
        checkOutput("idle_hi", hi, 0);
        checkOutput("idle_under", 32'(urs), 1);

        measurePeriod(0, hi, len, urs);
        applyStimulus(0, 8'h40);
        measurePeriod(0, hi, len, urs);
        checkOutput("d40_hi", hi, 64);
        checkOutput("d40_len", len, 256);
        checkOutput("d40_under", 32'(urs), 0);
        measurePeriod(0, hi, len, urs);
        checkOutput("d40_repeat_hi", hi, 64);
        checkOutput("d40_repeat_under", 32'(urs), 1);

        applyStimulus(0, 8'h00);
        measurePeriod(0, hi, len, urs);
        checkOutput("d00_hi", hi, 0);
        applyStimulus(0, 8'hFF);
        measurePeriod(0, hi, len, urs);
        checkOutput("dff_hi", hi, 255);
        checkOutput("dff_len", len, 256);

        // Back-to-back samples: the second stalls until the first is loaded.
        fork
            begin
                applyStimulus(0, 8'h10);
                applyStimulus(0, 8'h20);
            end
            begin
                measurePeriod(0, hi, len, urs);
                measurePeriod(0, hi2, len2, urs2);
            end
        join
        checkOutput("d10_hi", hi, 16);
        checkOutput("d10_under", 32'(urs), 0);
        checkOutput("d20_hi", hi2, 32);

        // Reset in the middle of a 0x80 period with 0xC0 waiting in the buffer.
        applyStimulus(0, 8'h80);
        waitFrame(0, ok);
        din = 8'hC0;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (99) @(negedge clk);
        checkOutput("pre_reset_pwm", 32'(pwm[0]), 1);
        checkOutput("pre_reset_ready", 32'(rdy[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", 32'(pwm[0]), 0);
        checkOutput("async_reset_ready", 32'(rdy[0]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measurePeriod(0, hi, len, urs);
        checkOutput("post_reset_hi", hi, 0);
        checkOutput("post_reset_under", 32'(urs), 1);
        checkOutput("post_reset_len", len, 256);
        measurePeriod(0, hi, len, urs);
        checkOutput("post_reset_hi2", hi, 0);

        // Prescaled instance.
        applyStimulus(1, 8'h80);
        measurePeriod(1, hi, len, urs);
        checkOutput("p3_len", len, 768);
        checkOutput("p3_hi", hi, 384);
        checkOutput("p3_under", 32'(urs), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
